// File: rtl/acq_sample_bank.sv
// ---------------------------------------------------------------------------
// acq_sample_bank
//
// Capture/replay sample memory feeding the acquisition unit. One contiguous
// frame of front-end samples is recorded. It is then replayed frame by frame,
// with an idle gap between frames, so one recorded frame can be correlated
// repeatedly across code-shift/Doppler passes.
//
// Ports:
//   clk                 system clock
//   reset               asynchronous active-low reset (0 = reset)
//   sample_valid        front-end sample strobe
//   sample_data         front-end sample
//   capture_start       begin capturing a new frame (honoured in IDLE only)
//   capture_busy        capture in progress
//   capture_done        one-cycle pulse when the frame is complete
//   frame_valid         buffer holds a complete frame
//   playback_start      begin replay (honoured in IDLE with frame_valid only)
//   num_frames          frames to replay, 0 = continuous
//   playback_stop       end replay at the next frame boundary
//   playback_busy       replay in progress
//   playback_done       one-cycle pulse after the last frame's gap
//   mem_data_available  replayed sample valid
//   mem_data            replayed sample (holds its value when not valid)
//   frame_start         high with the first sample of each frame
//   frame_end           high with the last sample of each frame
// ---------------------------------------------------------------------------
module acq_sample_bank #(
  parameter int unsigned DATA_WIDTH = 3,
  parameter int unsigned FRAME_LEN  = 16368,
  parameter int unsigned ADDR_WIDTH = 14,
  parameter int unsigned GAP_CYCLES = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sample_valid,
  input  logic [DATA_WIDTH-1:0] sample_data,
  input  logic                  capture_start,
  output logic                  capture_busy,
  output logic                  capture_done,
  output logic                  frame_valid,
  input  logic                  playback_start,
  input  logic [7:0]            num_frames,
  input  logic                  playback_stop,
  output logic                  playback_busy,
  output logic                  playback_done,
  output logic                  mem_data_available,
  output logic [DATA_WIDTH-1:0] mem_data,
  output logic                  frame_start,
  output logic                  frame_end
);

  localparam int unsigned GW = $clog2(GAP_CYCLES + 1);

  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ADDR_WIDTH'(FRAME_LEN - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);
  localparam logic [GW-1:0]         GAP_LAST  = GW'(GAP_CYCLES - 1);
  localparam logic [GW-1:0]         GAP_END   = GW'(GAP_CYCLES);
  localparam logic [GW-1:0]         GAP_ONE   = GW'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CAPTURE,
    S_READ,
    S_GAP
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [GW-1:0]         gap_cnt;
  logic [7:0]            frames_left;
  logic                  continuous;
  logic                  stop_pending;

  // Sample storage: one write port, registered read.
  logic [DATA_WIDTH-1:0] mem [FRAME_LEN];
  logic [DATA_WIDTH-1:0] ram_q;

  // Read-side pipeline flags, aligned with ram_q.
  logic rd_v1;
  logic rd_first1;
  logic rd_last1;

  logic stop_now;
  logic last_frame;
  logic do_write;
  logic in_read;

  assign stop_now   = stop_pending | playback_stop;
  assign last_frame = ~continuous & (frames_left == 8'd1);
  assign do_write   = (state == S_CAPTURE) & sample_valid;
  assign in_read    = (state == S_READ);

  // Memory has no reset; its contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (do_write) begin
      mem[wr_addr] <= sample_data;
    end
    ram_q <= mem[rd_addr];
  end

  // Control FSM with registered status outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= S_IDLE;
      wr_addr       <= '0;
      rd_addr       <= '0;
      gap_cnt       <= '0;
      frames_left   <= '0;
      continuous    <= 1'b0;
      stop_pending  <= 1'b0;
      capture_busy  <= 1'b0;
      capture_done  <= 1'b0;
      frame_valid   <= 1'b0;
      playback_busy <= 1'b0;
      playback_done <= 1'b0;
    end else begin
      capture_done  <= 1'b0;
      playback_done <= 1'b0;

      case (state)
        S_IDLE: begin
          stop_pending <= 1'b0;
          // Capture takes priority over a simultaneous playback request.
          if (capture_start) begin
            state        <= S_CAPTURE;
            wr_addr      <= '0;
            frame_valid  <= 1'b0;
            capture_busy <= 1'b1;
          end else if (playback_start && frame_valid) begin
            state         <= S_READ;
            rd_addr       <= '0;
            frames_left   <= num_frames;
            continuous    <= (num_frames == 8'd0);
            playback_busy <= 1'b1;
          end
        end

        S_CAPTURE: begin
          if (sample_valid) begin
            if (wr_addr == ADDR_LAST) begin
              state        <= S_IDLE;
              wr_addr      <= '0;
              capture_done <= 1'b1;
              capture_busy <= 1'b0;
              frame_valid  <= 1'b1;
            end else begin
              wr_addr <= wr_addr + ADDR_ONE;
            end
          end
        end

        S_READ: begin
          if (playback_stop) begin
            stop_pending <= 1'b1;
          end
          if (rd_addr == ADDR_LAST) begin
            state   <= S_GAP;
            rd_addr <= '0;
            gap_cnt <= '0;
          end else begin
            rd_addr <= rd_addr + ADDR_ONE;
          end
        end

        S_GAP: begin
          if (playback_stop) begin
            stop_pending <= 1'b1;
          end
          // The replayed stream trails the read address by two cycles, so a
          // terminating gap runs one extra cycle: done then lands exactly
          // GAP_CYCLES cycles after the final replayed frame_end.
          if (gap_cnt == GAP_LAST) begin
            if (stop_now || last_frame) begin
              gap_cnt <= gap_cnt + GAP_ONE;
            end else begin
              state <= S_READ;
              if (!continuous) begin
                frames_left <= frames_left - 8'd1;
              end
            end
          end else if (gap_cnt == GAP_END) begin
            state         <= S_IDLE;
            playback_done <= 1'b1;
            playback_busy <= 1'b0;
            stop_pending  <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt + GAP_ONE;
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Replay output stage: registered one cycle behind the RAM read data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_v1              <= 1'b0;
      rd_first1          <= 1'b0;
      rd_last1           <= 1'b0;
      mem_data_available <= 1'b0;
      mem_data           <= '0;
      frame_start        <= 1'b0;
      frame_end          <= 1'b0;
    end else begin
      rd_v1              <= in_read;
      rd_first1          <= in_read & (rd_addr == '0);
      rd_last1           <= in_read & (rd_addr == ADDR_LAST);
      mem_data_available <= rd_v1;
      frame_start        <= rd_first1;
      frame_end          <= rd_last1;
      if (rd_v1) begin
        mem_data <= ram_q;
      end
    end
  end

endmodule
